// File: rtl/dallanma_pkg.sv
// Shared encodings and helpers for the gshare predictor.
// Instruction kinds, 2-bit counter constants, checkpoint width.
package dallanma_pkg;

  localparam logic [1:0] TUR_BRANCH = 2'b00;
  localparam logic [1:0] TUR_JAL    = 2'b01;
  localparam logic [1:0] TUR_CALL   = 2'b10;
  localparam logic [1:0] TUR_RET    = 2'b11;

  localparam logic [1:0] SAYAC_GZ  = 2'b01;
  localparam logic [1:0] SAYAC_MAX = 2'b11;

  function automatic int ras_anlik_w(input int derinlik);
    return 2 * $clog2(derinlik) + 1;
  endfunction

endpackage

// File: rtl/ras_yigini.sv
// Circular return-address stack with checkpoint restore.
// Restore selects the base {ptr,count}; push/pop then apply on top of it.
module ras_yigini #(
  parameter int RAS_DERINLIK = 8,
  parameter int PC_W         = 32,
  localparam int RAS_PW      = $clog2(RAS_DERINLIK)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [PC_W-1:0]   push_data,
  input  logic              restore,
  input  logic [RAS_PW-1:0] restore_ptr,
  input  logic [RAS_PW:0]   restore_count,
  output logic [PC_W-1:0]   top,
  output logic [RAS_PW-1:0] ptr,
  output logic [RAS_PW:0]   count
);

  localparam logic [RAS_PW:0]   DOLU  = (RAS_PW + 1)'(RAS_DERINLIK);
  localparam logic [RAS_PW:0]   BIR_C = (RAS_PW + 1)'(1);
  localparam logic [RAS_PW-1:0] BIR_P = RAS_PW'(1);

  logic [PC_W-1:0]   mem [RAS_DERINLIK];
  logic [RAS_PW-1:0] base_ptr, ptr_n;
  logic [RAS_PW:0]   base_cnt, cnt_n;

  always_comb begin
    base_ptr = restore ? restore_ptr : ptr;
    base_cnt = restore ? restore_count : count;
    ptr_n    = base_ptr;
    cnt_n    = base_cnt;
    if (push) begin
      ptr_n = base_ptr + BIR_P;
      if (base_cnt != DOLU) cnt_n = base_cnt + BIR_C;
    end else if (pop && base_cnt != '0) begin
      ptr_n = base_ptr - BIR_P;
      cnt_n = base_cnt - BIR_C;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr   <= '0;
      count <= '0;
    end else begin
      ptr   <= ptr_n;
      count <= cnt_n;
    end
  end

  // Entries are never cleared; a full stack overwrites the oldest slot.
  always_ff @(posedge clk) begin
    if (push) mem[ptr_n] <= push_data;
  end

  assign top = mem[ptr];

endmodule

// File: rtl/gshare_dallanma_ongorucu.sv
// gshare predictor: PHT of 2-bit counters, tagged BTB, circular RAS.
// One request per cycle, registered prediction with GHR/RAS checkpoint.
module gshare_dallanma_ongorucu
  import dallanma_pkg::*;
#(
  parameter int PC_W         = 32,
  parameter int PHT_GIRIS    = 64,
  parameter int GHR_W        = 6,
  parameter int BTB_GIRIS    = 32,
  parameter int TAG_W        = 8,
  parameter int RAS_DERINLIK = 8,
  localparam int PHT_IDX     = $clog2(PHT_GIRIS),
  localparam int BTB_IDX     = $clog2(BTB_GIRIS),
  localparam int RAS_PW      = $clog2(RAS_DERINLIK),
  localparam int CKP_W       = ras_anlik_w(RAS_DERINLIK)
) (
  input  logic             clk_g,
  input  logic             rst_g,
  input  logic             i_istek_gecerli,
  input  logic [PC_W-1:0]  i_istek_pc,
  input  logic [1:0]       i_istek_tur,
  input  logic             i_istek_comp,
  output logic             o_ongoru_gecerli,
  output logic             o_atla,
  output logic [PC_W-1:0]  o_hedef,
  output logic             o_btb_isabet,
  output logic [GHR_W-1:0] o_ghr_anlik,
  output logic [CKP_W-1:0] o_ras_anlik,
  input  logic             guncelle_gecerli_g,
  input  logic [PC_W-1:0]  i_g_pc,
  input  logic [1:0]       i_g_tur,
  input  logic             i_g_comp,
  input  logic             i_g_atladi,
  input  logic [PC_W-1:0]  i_g_hedef,
  input  logic             i_g_yanlis,
  input  logic [GHR_W-1:0] i_g_ghr,
  input  logic [CKP_W-1:0] i_g_ras
);

  logic [GHR_W-1:0]   ghr, ghr_n;
  logic [1:0]         pht [PHT_GIRIS];
  logic [BTB_GIRIS-1:0] btb_val;
  logic [TAG_W-1:0]   btb_tag [BTB_GIRIS];
  logic [PC_W-1:0]    btb_hdf [BTB_GIRIS];

  logic               kurtar, istek;
  logic [PHT_IDX-1:0] p_idx, g_pidx;
  logic [BTB_IDX-1:0] b_idx, g_bidx;
  logic [TAG_W-1:0]   p_tag, g_tag;
  logic [PC_W-1:0]    link_i, link_g;
  logic               isabet, sel_ras, sel_btb, sel_yok;
  logic               atla_c;
  logic [PC_W-1:0]    hedef_c;
  logic [1:0]         sayac, sayac_n;
  logic               btb_yaz;

  logic               ras_push, ras_pop;
  logic [PC_W-1:0]    ras_data, ras_top;
  logic [RAS_PW-1:0]  ras_ptr;
  logic [RAS_PW:0]    ras_cnt;

  logic unused_pc;
  assign unused_pc = ^{i_istek_pc, i_g_pc};

  // A mispredict squashes any request arriving in the same cycle.
  assign kurtar = guncelle_gecerli_g & i_g_yanlis;
  assign istek  = i_istek_gecerli & ~kurtar;

  assign p_idx  = i_istek_pc[PHT_IDX+1:2] ^ PHT_IDX'(ghr);
  assign b_idx  = i_istek_pc[BTB_IDX+1:2];
  assign p_tag  = i_istek_pc[BTB_IDX+2 +: TAG_W];
  assign g_pidx = i_g_pc[PHT_IDX+1:2] ^ PHT_IDX'(i_g_ghr);
  assign g_bidx = i_g_pc[BTB_IDX+1:2];
  assign g_tag  = i_g_pc[BTB_IDX+2 +: TAG_W];

  assign link_i = i_istek_pc + (i_istek_comp ? PC_W'(2) : PC_W'(4));
  assign link_g = i_g_pc + (i_g_comp ? PC_W'(2) : PC_W'(4));

  assign isabet  = btb_val[b_idx] & (btb_tag[b_idx] == p_tag);
  assign sel_ras = (i_istek_tur == TUR_RET) & (ras_cnt != '0);
  assign sel_btb = isabet & ~sel_ras;
  assign sel_yok = ~isabet & ~sel_ras;

  always_comb begin
    atla_c  = 1'b0;
    hedef_c = link_i;
    unique case (1'b1)
      sel_ras: begin
        atla_c  = 1'b1;
        hedef_c = ras_top;
      end
      sel_btb: begin
        hedef_c = btb_hdf[b_idx];
        atla_c  = (i_istek_tur == TUR_BRANCH) ? pht[p_idx][1] : 1'b1;
      end
      sel_yok: begin
        atla_c  = 1'b0;
        hedef_c = link_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_g or posedge rst_g) begin
    if (rst_g) begin
      o_ongoru_gecerli <= 1'b0;
      o_atla           <= 1'b0;
      o_hedef          <= '0;
      o_btb_isabet     <= 1'b0;
      o_ghr_anlik      <= '0;
      o_ras_anlik      <= '0;
    end else begin
      o_ongoru_gecerli <= istek;
      o_atla           <= atla_c;
      o_hedef          <= hedef_c;
      o_btb_isabet     <= isabet;
      o_ghr_anlik      <= ghr;
      o_ras_anlik      <= {ras_ptr, ras_cnt};
    end
  end

  always_comb begin
    ghr_n = ghr;
    if (kurtar) begin
      ghr_n = (i_g_tur == TUR_BRANCH) ?
              GHR_W'({i_g_ghr, i_g_atladi}) : i_g_ghr;
    end else if (istek && i_istek_tur == TUR_BRANCH) begin
      ghr_n = GHR_W'({ghr, atla_c});
    end
  end

  always_ff @(posedge clk_g or posedge rst_g) begin
    if (rst_g) ghr <= '0;
    else       ghr <= ghr_n;
  end

  always_comb begin
    sayac   = pht[g_pidx];
    sayac_n = sayac;
    if (i_g_atladi) begin
      if (sayac != SAYAC_MAX) sayac_n = sayac + 2'd1;
    end else begin
      if (sayac != 2'b00) sayac_n = sayac - 2'd1;
    end
  end

  always_ff @(posedge clk_g or posedge rst_g) begin
    if (rst_g) begin
      for (int i = 0; i < PHT_GIRIS; i++) pht[i] <= SAYAC_GZ;
    end else if (guncelle_gecerli_g && i_g_tur == TUR_BRANCH) begin
      pht[g_pidx] <= sayac_n;
    end
  end

  assign btb_yaz = guncelle_gecerli_g & i_g_atladi & (i_g_tur != TUR_RET);

  always_ff @(posedge clk_g or posedge rst_g) begin
    if (rst_g)        btb_val <= '0;
    else if (btb_yaz) btb_val[g_bidx] <= 1'b1;
  end

  always_ff @(posedge clk_g) begin
    if (btb_yaz) begin
      btb_tag[g_bidx] <= g_tag;
      btb_hdf[g_bidx] <= i_g_hedef;
    end
  end

  // Recovery replays the resolved call/return on top of its checkpoint.
  always_comb begin
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    ras_data = link_i;
    if (kurtar) begin
      ras_push = (i_g_tur == TUR_CALL);
      ras_pop  = (i_g_tur == TUR_RET);
      ras_data = link_g;
    end else if (istek) begin
      ras_push = (i_istek_tur == TUR_CALL);
      ras_pop  = (i_istek_tur == TUR_RET);
    end
  end

  ras_yigini #(
    .RAS_DERINLIK(RAS_DERINLIK),
    .PC_W        (PC_W)
  ) u_ras (
    .clk          (clk_g),
    .rst          (rst_g),
    .push         (ras_push),
    .pop          (ras_pop),
    .push_data    (ras_data),
    .restore      (kurtar),
    .restore_ptr  (i_g_ras[2*RAS_PW:RAS_PW+1]),
    .restore_count(i_g_ras[RAS_PW:0]),
    .top          (ras_top),
    .ptr          (ras_ptr),
    .count        (ras_cnt)
  );

endmodule

// File: tb/tb_gshare_dallanma_ongorucu.sv
// Directed bench for the gshare predictor.
// Hand-computed vectors: reset, training, RAS, recovery, async reset.
module tb_gshare_dallanma_ongorucu;

  logic        clk, rst;
  logic        rq_v, rq_comp;
  logic [31:0] rq_pc;
  logic [1:0]  rq_tur;
  logic        o_v, o_atla, o_isabet;
  logic [31:0] o_hedef;
  logic [5:0]  o_ghr;
  logic [6:0]  o_ras;
  logic        u_v, u_comp, u_atl, u_yan;
  logic [31:0] u_pc, u_hdf;
  logic [1:0]  u_tur;
  logic [5:0]  u_ghr;
  logic [6:0]  u_ras;

  int vec_cnt  = 0;
  int miss_cnt = 0;
  logic [31:0] exp_h;

  gshare_dallanma_ongorucu dut (
    .clk_g             (clk),
    .rst_g             (rst),
    .i_istek_gecerli   (rq_v),
    .i_istek_pc        (rq_pc),
    .i_istek_tur       (rq_tur),
    .i_istek_comp      (rq_comp),
    .o_ongoru_gecerli  (o_v),
    .o_atla            (o_atla),
    .o_hedef           (o_hedef),
    .o_btb_isabet      (o_isabet),
    .o_ghr_anlik       (o_ghr),
    .o_ras_anlik       (o_ras),
    .guncelle_gecerli_g(u_v),
    .i_g_pc            (u_pc),
    .i_g_tur           (u_tur),
    .i_g_comp          (u_comp),
    .i_g_atladi        (u_atl),
    .i_g_hedef         (u_hdf),
    .i_g_yanlis        (u_yan),
    .i_g_ghr           (u_ghr),
    .i_g_ras           (u_ras)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] act,
                       input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic req(input logic [31:0] pc, input logic [1:0] tur,
                     input logic comp);
    rq_v = 1'b1; rq_pc = pc; rq_tur = tur; rq_comp = comp;
    @(posedge clk); #1;
    rq_v = 1'b0;
  endtask

  task automatic upd(input logic [31:0] pc, input logic [1:0] tur,
                     input logic atl, input logic [31:0] hdf,
                     input logic yan, input logic [5:0] gh,
                     input logic [6:0] rs);
    u_v = 1'b1; u_pc = pc; u_tur = tur; u_comp = 1'b0;
    u_atl = atl; u_hdf = hdf; u_yan = yan; u_ghr = gh; u_ras = rs;
    @(posedge clk); #1;
    u_v = 1'b0; u_yan = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    rq_v = 0; rq_pc = 0; rq_tur = 0; rq_comp = 0;
    u_v = 0; u_pc = 0; u_tur = 0; u_comp = 0;
    u_atl = 0; u_hdf = 0; u_yan = 0; u_ghr = 0; u_ras = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", o_v, 0);
    check("rst_atla", o_atla, 0);
    check("rst_hedef", o_hedef, 0);
    check("rst_isabet", o_isabet, 0);
    check("rst_ghr", o_ghr, 0);
    check("rst_ras", o_ras, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_valid", o_v, 0);

    // first request after reset
    req(32'h100, 2'b00, 0);
    check("t1_valid", o_v, 1);
    check("t1_atla", o_atla, 0);
    check("t1_hedef", o_hedef, 32'h104);
    check("t1_isabet", o_isabet, 0);

    // training 01 -> 10 -> 11
    upd(32'h100, 2'b00, 1, 32'h200, 0, 6'd0, 7'h00);
    upd(32'h100, 2'b00, 1, 32'h200, 0, 6'd0, 7'h00);
    req(32'h100, 2'b00, 0);
    check("t2_atla", o_atla, 1);
    check("t2_hedef", o_hedef, 32'h200);
    check("t2_isabet", o_isabet, 1);
    check("t2_ghr", o_ghr, 0);
    upd(32'h1004, 2'b01, 1, 32'h1100, 1, 6'd0, 7'h00);

    // top saturation: 11 stays 11, then two decrements -> 01
    upd(32'h100, 2'b00, 1, 32'h200, 0, 6'd0, 7'h00);
    upd(32'h100, 2'b00, 0, 32'h104, 0, 6'd0, 7'h00);
    upd(32'h100, 2'b00, 0, 32'h104, 0, 6'd0, 7'h00);
    req(32'h100, 2'b00, 0);
    check("t2_sat_hi", o_atla, 0);
    check("t2_nt_hedef", o_hedef, 32'h200);
    check("t2_recov_ghr", o_ghr, 0);

    // bottom saturation at 00
    upd(32'h100, 2'b00, 0, 32'h104, 0, 6'd0, 7'h00);
    upd(32'h100, 2'b00, 0, 32'h104, 0, 6'd0, 7'h00);
    req(32'h100, 2'b00, 0);
    check("t2_sat_lo", o_atla, 0);
    upd(32'h100, 2'b00, 1, 32'h200, 0, 6'd0, 7'h00);
    upd(32'h100, 2'b00, 1, 32'h200, 0, 6'd0, 7'h00);
    req(32'h100, 2'b00, 0);
    check("t2_retrain", o_atla, 1);
    upd(32'h1004, 2'b01, 1, 32'h1100, 1, 6'd0, 7'h00);

    // RAS: three calls, three returns
    req(32'h10, 2'b10, 0);
    check("t3_call_hedef", o_hedef, 32'h14);
    req(32'h20, 2'b10, 0);
    req(32'h30, 2'b10, 0);
    req(32'h400, 2'b11, 0);
    check("t3_ras_ckp", o_ras, 7'h33);
    check("t3_ret1", o_hedef, 32'h34);
    check("t3_ret1_atla", o_atla, 1);
    req(32'h400, 2'b11, 0);
    check("t3_ret2", o_hedef, 32'h24);
    req(32'h400, 2'b11, 0);
    check("t3_ret3", o_hedef, 32'h14);

    // nine calls into an eight-deep stack
    for (int k = 1; k <= 9; k++) req(32'h1000 + 32'(k) * 16, 2'b10, 0);
    for (int j = 0; j < 8; j++) begin
      req(32'h400, 2'b11, 0);
      exp_h = 32'h1000 + 32'(9 - j) * 16 + 32'h4;
      check("t3_wrap_ret", o_hedef, exp_h);
    end
    req(32'h400, 2'b11, 1);
    check("t3_empty_atla", o_atla, 0);
    check("t3_empty_hedef", o_hedef, 32'h402);
    check("t3_empty_ckp", o_ras, 7'h10);

    // recovery: GHR 0 -> 1 -> 3, mispredict with checkpoint 1
    upd(32'h100, 2'b00, 1, 32'h200, 0, 6'd1, 7'h10);
    req(32'h100, 2'b00, 0);
    check("t4_p1_atla", o_atla, 1);
    check("t4_p1_ghr", o_ghr, 6'd0);
    req(32'h100, 2'b00, 0);
    check("t4_p2_atla", o_atla, 1);
    check("t4_p2_ghr", o_ghr, 6'd1);
    rq_pc = 32'h700; rq_tur = 2'b10; rq_comp = 0; rq_v = 1'b1;
    upd(32'h100, 2'b00, 0, 32'h104, 1, 6'd1, 7'h10);
    rq_v = 1'b0;
    check("t4_squash", o_v, 0);
    req(32'h100, 2'b00, 0);
    check("t4_ghr", o_ghr, 6'b000010);
    check("t4_ras_kept", o_ras, 7'h10);
    check("t4_atla", o_atla, 0);

    // RAS restore after a wrong-path return
    req(32'h500, 2'b10, 0);
    check("t5_call_ckp", o_ras, 7'h10);
    req(32'h600, 2'b11, 0);
    check("t5_wp_ret", o_hedef, 32'h504);
    upd(32'h500, 2'b10, 1, 32'h900, 1, 6'd4, 7'h10);
    req(32'h600, 2'b11, 0);
    check("t5_ckp", o_ras, 7'h21);
    check("t5_ret_hedef", o_hedef, 32'h504);
    check("t5_ret_atla", o_atla, 1);
    check("t5_ghr", o_ghr, 6'd4);

    // asynchronous reset between edges
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_valid", o_v, 0);
    check("t6_async_atla", o_atla, 0);
    check("t6_async_hedef", o_hedef, 0);
    check("t6_async_ras", o_ras, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("t6_valid", o_v, 0);
    req(32'h100, 2'b00, 0);
    check("t6_btb_clr", o_isabet, 0);
    check("t6_hedef", o_hedef, 32'h104);
    check("t6_ghr", o_ghr, 0);
    upd(32'h100, 2'b01, 1, 32'h300, 0, 6'd0, 7'h00);
    req(32'h100, 2'b00, 0);
    check("t6_isabet", o_isabet, 1);
    check("t6_hedef2", o_hedef, 32'h300);
    check("t6_pht_gz", o_atla, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
